// File: rtl/conv1_relu_maxpool.sv
// conv1_relu_maxpool: optional ReLU followed by 2x2 stride-2 max pooling on a
// stream of NUM_CH row-major IMG_H x IMG_W planes, valid/ready on both sides.
// A single half-width line buffer holds the pairwise row-0 maxima of each window.
// Optional feature macro: CONV1_POOL_RELU_EN (clamps negative samples to 0).
module conv1_relu_maxpool #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IMG_W  = 128,
   parameter int unsigned IMG_H  = 128,
   parameter int unsigned NUM_CH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_vld,
   output logic              in_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic              out_last,
   output logic              done
);

   localparam int unsigned COL_W  = $clog2(IMG_W);
   localparam int unsigned ROW_W  = $clog2(IMG_H);
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned HALF_W = IMG_W / 2;
   localparam int unsigned LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   state_t                    state;
   logic [COL_W-1:0]          col;
   logic [ROW_W-1:0]          row;
   logic [CH_W-1:0]           ch;
   logic signed [DATA_W-1:0]  h;
   logic signed [DATA_W-1:0]  lbuf [HALF_W];

   logic                      accept;
   logic                      col_last;
   logic                      row_last;
   logic                      ch_last;
   logic                      frame_last;
   logic [LB_AW-1:0]          lb_idx;
   logic signed [DATA_W-1:0]  x;
   logic signed [DATA_W-1:0]  pool_h;
   logic signed [DATA_W-1:0]  pool_o;

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign in_rdy     = (state == StRun) && (!out_vld || out_rdy);
   assign accept     = in_vld && in_rdy;
   assign col_last   = (col == COL_W'(IMG_W - 1));
   assign row_last   = (row == ROW_W'(IMG_H - 1));
   assign ch_last    = (ch == CH_W'(NUM_CH - 1));
   assign frame_last = col_last && row_last && ch_last;
   assign lb_idx     = LB_AW'(col >> 1);

   // Input sample after optional ReLU and the window maxima built from it
   always_comb begin
`ifdef CONV1_POOL_RELU_EN
      x = in_data[DATA_W-1] ? '0 : $signed(in_data);
`else
      x = $signed(in_data);
`endif
      pool_h = smax(h, x);
      pool_o = smax(lbuf[lb_idx], pool_h);
   end

   // Window datapath: h holds the even-column sample, lbuf the row-0 pair maxima
   always_ff @(posedge clk) begin
      if (accept) begin
         if (!col[0]) begin
            h <= x;
         end else if (!row[0]) begin
            lbuf[lb_idx] <= pool_h;
         end
      end
   end

   // Control FSM, position counters and the registered output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= StIdle;
         col      <= '0;
         row      <= '0;
         ch       <= '0;
         out_data <= '0;
         out_vld  <= 1'b0;
         out_last <= 1'b0;
         done     <= 1'b0;
      end else begin
         unique case (state)
            StIdle:  state <= StRun;
            StRun:   if (accept && frame_last) state <= StDrain;
            StDrain: begin
               if (out_vld && out_rdy) begin
                  state <= StDone;
                  done  <= 1'b1;
               end
            end
            StDone:  done <= 1'b1;
            default: state <= StIdle;
         endcase

         if (accept) begin
            if (col_last) begin
               col <= '0;
               if (row_last) begin
                  row <= '0;
                  ch  <= ch_last ? '0 : ch + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end

         // A new load wins over a same-cycle drain, so out_vld stays high
         if (accept && row[0] && col[0]) begin
            out_data <= pool_o;
            out_vld  <= 1'b1;
            out_last <= frame_last;
         end else if (out_rdy) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv1_relu_maxpool.sv
// Self-checking bench for conv1_relu_maxpool (4x4 planes, 2 channels).
// Expected words go into exp_q as stimulus is driven; accepted output words are
// captured into obs_q and compared in order.
module tb_conv1_relu_maxpool;

   localparam int DW    = 32;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int NC    = 2;
   localparam int FRAME = W * H * NC;
   localparam int NOUT  = FRAME / 4;

   typedef logic [DW:0] sb_t;  // {last, data}

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          in_vld;
   logic          in_rdy;
   logic [DW-1:0] out_data;
   logic          out_vld;
   logic          out_rdy;
   logic          out_last;
   logic          done;

   int  checks   = 0;
   int  failures = 0;
   int  rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: held low
   sb_t exp_q[$];
   sb_t obs_q[$];
   logic [DW-1:0] frm [FRAME];

   conv1_relu_maxpool #(
      .DATA_W (DW),
      .IMG_W  (W),
      .IMG_H  (H),
      .NUM_CH (NC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .out_data (out_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_last (out_last),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Capture every output handshake; the transfer completes on the next posedge
   always @(negedge clk) begin
      if (!reset && out_vld && out_rdy) obs_q.push_back({out_last, out_data});
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = 1'($urandom_range(1));
            default: out_rdy = 1'b0;
         endcase
      end
   end

   function automatic logic signed [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef CONV1_POOL_RELU_EN
      return v[DW-1] ? '0 : $signed(v);
`else
      return $signed(v);
`endif
   endfunction

   function automatic logic signed [DW-1:0] max2(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Golden 2x2 max over frm, pushed in output order
   task automatic push_model();
      for (int c = 0; c < NC; c++)
         for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++) begin
               int b = c * W * H + 2 * pr * W + 2 * pc;
               logic signed [DW-1:0] m;
               m = max2(max2(relu(frm[b]), relu(frm[b + 1])),
                        max2(relu(frm[b + W]), relu(frm[b + W + 1])));
               exp_q.push_back({(c == NC - 1 && pr == H / 2 - 1 && pc == W / 2 - 1), m});
            end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < FRAME; i++) frm[i] = DW'(i);
   endtask

   task automatic apply_reset();
      reset  = 1'b1;
      in_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   // Send nbeats words of frm; gap_pct is the chance of idling in_vld per cycle
   task automatic drive_frame(input int gap_pct, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         int guard = 0;
         bit sent  = 1'b0;
         in_data = frm[i];
         while (!sent) begin
            in_vld = ($urandom_range(99) >= gap_pct);
            @(negedge clk);
            if (in_vld && in_rdy) sent = 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (!sent && guard > 500) begin
               checks++;
               failures++;
               $display("FAIL drive_timeout: beat %0d not accepted, got in_rdy=%0b, required 1",
                        i, in_rdy);
               in_vld = 1'b0;
               return;
            end
         end
      end
      in_vld = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      int guard = 0;
      while (obs_q.size() < n && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (obs_q.size() < n) begin
         checks++;
         failures++;
         $display("FAIL out_timeout: got %0d words, required %0d", obs_q.size(), n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({out_vld, out_last, done, in_rdy} !== 4'b0000 || out_data !== '0) begin
         failures++;
         $display("FAIL reset_state: got vld=%0b last=%0b done=%0b in_rdy=%0b data=%h, required 0",
                  out_vld, out_last, done, in_rdy, out_data);
      end
   endtask

   task automatic test_ramp();
      int ref_out [NOUT] = '{5, 7, 13, 15, 21, 23, 29, 31};
      sb_t e, o;
      apply_reset();
      fill_ramp();
      for (int k = 0; k < NOUT; k++) exp_q.push_back({(k == NOUT - 1), DW'(ref_out[k])});
      drive_frame(0, FRAME);
      wait_obs(NOUT);
      checks++;
      if (done !== 1'b1 || in_rdy !== 1'b0) begin
         failures++;
         $display("FAIL ramp_done: got done=%0b in_rdy=%0b, required done=1 in_rdy=0", done, in_rdy);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL ramp_word: got last=%0b data=%h, required last=%0b data=%h",
                     o[DW], o[DW-1:0], e[DW], e[DW-1:0]);
         end
      end
   endtask

   task automatic test_negatives();
      logic [DW-1:0] want;
      sb_t o;
`ifdef CONV1_POOL_RELU_EN
      want = '0;
`else
      want = -32'sd5;
`endif
      apply_reset();
      for (int i = 0; i < FRAME; i++) frm[i] = (i < W * H) ? -32'sd5 : DW'(i);
      push_model();
      drive_frame(0, FRAME);
      wait_obs(NOUT);
      for (int k = 0; k < 4 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         void'(exp_q.pop_front());
         checks++;
         if (o[DW-1:0] !== want) begin
            failures++;
            $display("FAIL neg_word%0d: got %h, required %h", k, o[DW-1:0], want);
         end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         sb_t e;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL neg_plane1: got %h, required %h", o, e);
         end
      end
   endtask

   task automatic test_backpressure();
      sb_t e, o;
      apply_reset();
      fill_ramp();
      push_model();
      rdy_mode = 2;
      out_rdy  = 1'b0;
      fork
         drive_frame(0, FRAME);
         begin
            int guard = 0;
            while (!out_vld && guard < 500) begin
               @(negedge clk);
               guard++;
            end
            repeat (10) begin
               @(negedge clk);
               checks++;
               if (out_vld !== 1'b1 || out_data !== 32'd5 || in_rdy !== 1'b0) begin
                  failures++;
                  $display("FAIL bp_hold: got vld=%0b data=%h in_rdy=%0b, required 1/5/0",
                           out_vld, out_data, in_rdy);
               end
            end
            @(posedge clk);
            #1;
            rdy_mode = 0;
            out_rdy  = 1'b1;
         end
      join
      wait_obs(NOUT);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL bp_word: got %h, required %h", o, e);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int ref_out [NOUT] = '{5, 7, 13, 15, 21, 23, 29, 31};
      sb_t e, o;
      apply_reset();
      fill_ramp();
      drive_frame(0, 9);
      apply_reset();
      checks++;
      if (out_vld !== 1'b0) begin
         failures++;
         $display("FAIL midreset_vld: got out_vld=%0b, required 0", out_vld);
      end
      for (int k = 0; k < NOUT; k++) exp_q.push_back({(k == NOUT - 1), DW'(ref_out[k])});
      drive_frame(0, FRAME);
      wait_obs(NOUT);
      checks++;
      if (obs_q.size() != NOUT) begin
         failures++;
         $display("FAIL midreset_count: got %0d words, required %0d", obs_q.size(), NOUT);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL midreset_word: got %h, required %h", o, e);
         end
      end
   endtask

   task automatic test_edge_values();
      sb_t o;
      apply_reset();
      for (int i = 0; i < FRAME; i++) frm[i] = '0;
      frm[0]     = 32'h8000_0000;
      frm[1]     = 32'h7FFF_FFFF;
      frm[W]     = 32'h8000_0000;
      frm[W + 1] = 32'h8000_0000;
      drive_frame(0, FRAME);
      wait_obs(NOUT);
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (o[DW-1:0] !== 32'h7FFF_FFFF) begin
            failures++;
            $display("FAIL edge_max: got %h, required 7fffffff", o[DW-1:0]);
         end
      end
   endtask

   task automatic test_random();
      sb_t e, o;
      for (int f = 0; f < 200; f++) begin
         apply_reset();
         for (int i = 0; i < FRAME; i++)
            frm[i] = ($urandom_range(3) == 0) ? DW'($urandom) : DW'($urandom_range(40)) - 20;
         push_model();
         rdy_mode = 1;
         drive_frame(50, FRAME);
         wait_obs(NOUT);
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL random_word: frame %0d got %h, required %h", f, o, e);
            end
         end
      end
      rdy_mode = 0;
   endtask

   initial begin
      reset   = 1'b1;
      in_vld  = 1'b0;
      in_data = '0;
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_ramp();
      test_negatives();
      test_backpressure();
      test_reset_mid_frame();
      test_edge_values();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
